// File: rtl/pkt_ring_ctrl_if.sv
// Handshake and status bundle between the ingress/reader side and pkt_ring_ctrl.
// The master drives requests; the slave (controller) drives register-file controls and status.
interface pkt_ring_ctrl_if #(
    parameter int unsigned pWIDHT = 2
);
    logic              iwr_req;
    logic              iwr_last;
    logic              ird_req;
    logic              owr_en;
    logic [pWIDHT-1:0] ow_addr;
    logic [pWIDHT-1:0] or_addr;
    logic              ovalid;
    logic              ord_last;
    logic              ofull;
    logic              odrop;
    logic [pWIDHT:0]   ocnt;

    modport master (
        output iwr_req, iwr_last, ird_req,
        input  owr_en, ow_addr, or_addr, ovalid, ord_last, ofull, odrop, ocnt
    );

    modport slave (
        input  iwr_req, iwr_last, ird_req,
        output owr_en, ow_addr, or_addr, ovalid, ord_last, ofull, odrop, ocnt
    );
endinterface

// File: rtl/pkt_ring_ctrl.sv
// Store-and-forward packet ring controller: drives a 2**pWIDHT-word register file,
// exposes only committed packets to the reader and drops packets that do not fit.
module pkt_ring_ctrl #(
    parameter int unsigned pWIDHT = 2
) (
    input  logic                  iclk,
    input  logic                  irst,
    pkt_ring_ctrl_if.slave        bus
);
    localparam int unsigned     DEPTH     = 2 ** pWIDHT;
    localparam logic [pWIDHT:0] FULL_DIST = (pWIDHT + 1)'(DEPTH);
    localparam logic [pWIDHT:0] PTR_ONE   = (pWIDHT + 1)'(1);

    localparam logic ST_STORE = 1'b0;
    localparam logic ST_DROP  = 1'b1;

    logic [pWIDHT:0]   r_wr_ptr;
    logic [pWIDHT:0]   r_cm_ptr;
    logic [pWIDHT:0]   r_rd_ptr;
    logic              r_state;
    logic              r_drop;
    logic [DEPTH-1:0]  r_last_flag;

    logic              w_full;
    logic              w_store;
    logic              w_accept;
    logic              w_ovf;
    logic              w_valid;
    logic              w_rd;
    logic [pWIDHT:0]   w_wr_ptr_inc;
    logic [pWIDHT-1:0] w_wr_addr;
    logic [pWIDHT-1:0] w_rd_addr;

    always_comb begin
        w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
        w_wr_addr    = r_wr_ptr[pWIDHT-1:0];
        w_rd_addr    = r_rd_ptr[pWIDHT-1:0];
        // Full uses registered pointers only: a read this cycle frees no space until next cycle.
        w_full       = (r_wr_ptr - r_rd_ptr) == FULL_DIST;
        w_store      = (r_state == ST_STORE);
        w_accept     = w_store & bus.iwr_req & ~w_full;
        w_ovf        = w_store & bus.iwr_req & w_full;
        w_valid      = (r_rd_ptr != r_cm_ptr);
        w_rd         = bus.ird_req & w_valid;
    end

    always_comb begin
        bus.owr_en   = w_accept & ~irst;
        bus.ow_addr  = w_wr_addr;
        bus.or_addr  = w_rd_addr;
        bus.ovalid   = w_valid;
        bus.ord_last = r_last_flag[w_rd_addr];
        bus.ofull    = w_full;
        bus.odrop    = r_drop;
        bus.ocnt     = r_cm_ptr - r_rd_ptr;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_wr_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= ST_STORE;
            r_drop      <= 1'b0;
            r_last_flag <= '0;
        end else begin
            r_drop <= w_ovf;
            if (w_accept) begin
                r_wr_ptr               <= w_wr_ptr_inc;
                r_last_flag[w_wr_addr] <= bus.iwr_last;
                if (bus.iwr_last) begin
                    r_cm_ptr <= w_wr_ptr_inc;
                end
            end else if (w_ovf) begin
                // Rewind discards the partial packet; the rest of it is swallowed in DROP.
                r_wr_ptr <= r_cm_ptr;
                if (!bus.iwr_last) begin
                    r_state <= ST_DROP;
                end
            end else if (r_state == ST_DROP && bus.iwr_req && bus.iwr_last) begin
                r_state <= ST_STORE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_pkt_ring_ctrl.sv
// Bench for pkt_ring_ctrl: directed packet scenarios then random traffic, all checked
// against a queue-based packet FIFO model.
module tb_pkt_ring_ctrl;
    localparam int W = 2;
    localparam int D = 2 ** W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pkt_ring_ctrl_if #(.pWIDHT(W)) bus ();

    pkt_ring_ctrl #(.pWIDHT(W)) u_dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Model: committed words, pending words of the open packet, read address, flag memory.
    bit mq[$];
    bit pq[$];
    int rd_addr;
    bit dropping;
    bit drop_pend;
    bit fmem[D];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pq.delete();
        rd_addr   = 0;
        dropping  = 1'b0;
        drop_pend = 1'b0;
        for (int i = 0; i < D; i++) fmem[i] = 1'b0;
    endtask

    task automatic check_outputs(input bit req, input bit in_rst);
        int occ;
        bit full;
        occ  = mq.size() + pq.size();
        full = (occ == D);
        check("owr_en",   32'(bus.owr_en),   32'(!in_rst && !dropping && req && !full));
        check("ow_addr",  32'(bus.ow_addr),  32'((rd_addr + occ) % D));
        check("or_addr",  32'(bus.or_addr),  32'(rd_addr));
        check("ovalid",   32'(bus.ovalid),   32'(mq.size() > 0));
        check("ord_last", 32'(bus.ord_last), 32'(fmem[rd_addr]));
        check("ofull",    32'(bus.ofull),    32'(full));
        check("odrop",    32'(bus.odrop),    32'(drop_pend));
        check("ocnt",     32'(bus.ocnt),     32'(mq.size()));
    endtask

    task automatic model_update(input bit req, input bit last, input bit rd);
        int occ;
        int mq_pre;
        bit drop_n;
        occ    = mq.size() + pq.size();
        mq_pre = mq.size();
        drop_n = 1'b0;
        if (!dropping && req) begin
            if (occ < D) begin
                fmem[(rd_addr + occ) % D] = last;
                pq.push_back(last);
                if (last) begin
                    foreach (pq[i]) mq.push_back(pq[i]);
                    pq.delete();
                end
            end else begin
                pq.delete();
                drop_n   = 1'b1;
                dropping = !last;
            end
        end else if (dropping && req && last) begin
            dropping = 1'b0;
        end
        if (rd && mq_pre > 0) begin
            void'(mq.pop_front());
            rd_addr = (rd_addr + 1) % D;
        end
        drop_pend = drop_n;
    endtask

    task automatic step(input bit req, input bit last, input bit rd);
        @(negedge clk);
        bus.iwr_req  = req;
        bus.iwr_last = last;
        bus.ird_req  = rd;
        #1;
        check_outputs(req, 1'b0);
        @(posedge clk);
        model_update(req, last, rd);
    endtask

    // Asynchronous reset asserted mid-cycle with a write request held to show owr_en is forced low.
    task automatic do_reset();
        @(negedge clk);
        bus.iwr_req  = 1'b1;
        bus.iwr_last = 1'b0;
        bus.ird_req  = 1'b1;
        rst          = 1'b1;
        model_clear();
        #1;
        check_outputs(1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.iwr_req  = 1'b0;
        bus.iwr_last = 1'b0;
        bus.ird_req  = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int i = 1; i <= len; i++) step(1'b1, i == len, 1'b0);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.iwr_req  = 1'b0;
        bus.iwr_last = 1'b0;
        bus.ird_req  = 1'b0;
        model_clear();
        do_reset();

        // 3-word packet, then drain it.
        send_pkt(3);
        step(1'b0, 1'b0, 1'b0);
        read_n(3);
        step(1'b0, 1'b0, 1'b0);

        // Single-word packet from a clean buffer.
        do_reset();
        send_pkt(1);
        step(1'b0, 1'b0, 1'b0);

        // 3 committed words, 2-word packet overflows on its second word.
        do_reset();
        send_pkt(3);
        send_pkt(2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // 6-word packet into empty buffer, then a 1-word packet.
        do_reset();
        send_pkt(6);
        send_pkt(1);
        step(1'b0, 1'b0, 1'b0);

        // Full with 4 committed words: simultaneous read and write, then wrap write.
        do_reset();
        send_pkt(4);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        read_n(5);

        // Reset mid-packet, then a fresh packet.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        do_reset();
        send_pkt(2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(99) < 60, $urandom_range(99) < 25, $urandom_range(99) < 40);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pkt_ring_ctrl.md
Name: pkt_ring_ctrl

Overview:
Packet-aware ring-buffer controller that sequences a single-port-write / async-read register file (depth 2**pWIDHT) as a store-and-forward packet FIFO.
- Generates write enable, write address and read address for the register file.
- Tracks a per-entry end-of-packet flag.
- Exposes only fully committed packets to the reader.
- Drops a packet whole when it does not fit.
- Sits between the packet ingress framer and the copy/egress logic.

Parameters:
pWIDHT, 2, register-file address width; buffer depth = 2**pWIDHT words.

Ports:
iclk  in  1  clock, all state on rising edge
irst  in  1  reset, asynchronous, active-high
iwr_req  in  1  ingress word valid this cycle
iwr_last  in  1  ingress word is last of packet (qualified by iwr_req)
ird_req  in  1  reader consumes current word (qualified by ovalid)
owr_en  out  1  register-file write enable
ow_addr  out  pWIDHT  register-file write address
or_addr  out  pWIDHT  register-file read address
ovalid  out  1  committed word available at or_addr
ord_last  out  1  word at or_addr is last of its packet
ofull  out  1  write pointer is depth ahead of read pointer
odrop  out  1  one-cycle pulse: a packet was discarded
ocnt  out  pWIDHT+1  committed, unread words (0..depth)

Behaviour:
- Pointers: wr_ptr (speculative), cm_ptr (commit), rd_ptr. Each is pWIDHT+1 bits and wraps mod 2**(pWIDHT+1). Addresses are the low pWIDHT bits.
- Write state machine has two states.
  - STORE (reset state): normal write path.
    - accept = iwr_req & ~ofull.
    - On accept: owr_en=1 combinationally, ow_addr=wr_ptr, wr_ptr++, last_flag[wr_ptr] <= iwr_last.
    - On accept with iwr_last: cm_ptr <= wr_ptr+1, which commits the packet.
  - Overflow: iwr_req & ofull.
    - No write. wr_ptr <= cm_ptr (rewind). odrop pulses the next cycle.
    - If iwr_last is 0, go to DROP; if it is 1, stay in STORE.
  - DROP: owr_en=0.
    - Discard every iwr_req word.
    - On iwr_req & iwr_last, return to STORE. No second odrop pulse.
- Full/empty:
  - ofull = (wr_ptr - rd_ptr) == 2**pWIDHT, computed from registered pointers.
  - ovalid = (rd_ptr != cm_ptr).
- A read in the same cycle does not free space for a write that cycle; there is no bypass.
- A packet longer than the depth therefore always overflows and is dropped.
- Read path:
  - or_addr = rd_ptr[pWIDHT-1:0] and ord_last = last_flag[or_addr], both combinational. Read data from the register file is therefore valid in the same cycle.
  - ird_req & ovalid: rd_ptr++.
  - ird_req with ~ovalid is ignored.
- A simultaneous commit and read is legal. ocnt = cm_ptr - rd_ptr, updated from registered values, so it reflects both changes one cycle later.
- Uncommitted words are never visible to the reader: ovalid and ocnt ignore wr_ptr.
- Reset behaviour (asynchronous, any time including mid-packet):
  - All pointers 0, state STORE, last_flag all 0, odrop 0.
  - Outputs while irst=1: owr_en=0, ow_addr=0, or_addr=0, ovalid=0, ord_last=0, ofull=0, ocnt=0.
  - Any partial packet is lost with no odrop pulse.
- owr_en is forced 0 while irst=1.

Test Plan:
1. pWIDHT=2; one 3-word packet (last on word 3) -> ow_addr 0,1,2. ovalid stays 0 until the cycle after word 3, then ocnt=3. Reading gives or_addr 0,1,2 with ord_last=0,0,1; then ovalid=0, ocnt=0.
2. Single-word packet (iwr_req=iwr_last=1) -> write at addr 0, commit next cycle, ocnt=1, ord_last=1.
3. Buffer holds committed 3 words, no reads; send 2-word packet -> word1 written at addr 3; word2 hits ofull, wr_ptr rewinds to 3, odrop pulses once. State stays STORE. ocnt remains 3.
4. Empty buffer, 6-word packet -> 4 words written, overflow on word5 (odrop, DROP state), word6 discarded. Next 1-word packet is written at addr 0 and commits; ocnt=1.
5. Full with 4 committed words; assert ird_req and iwr_req in same cycle -> read advances, write rejected (overflow drop). Next cycle ofull=0 and a write is accepted at addr 0 (wrap). Pointer MSB toggles; ofull/ovalid stay correct.
6. Assert irst mid-packet after 2 uncommitted words -> immediately owr_en=0, ovalid=0, ocnt=0. After release, a new packet is written from addr 0 and odrop never pulses.
